// File: rtl/ap_ctrl_driver_pkg.sv
// Shared types for the ap_ctrl_chain initiator: controller states, counter
// typedefs and FIFO sizing helper.
package ap_ctrl_driver_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  typedef logic [CNT_W_DEF-1:0] cnt_t;
  typedef logic [CNT_W_DEF-1:0] lat_t;

  // Pointer width for a FIFO of the given depth; a depth-1 FIFO still gets one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ap_ctrl_ts_fifo.sv
// Show-ahead timestamp FIFO holding the start-accept time of each outstanding
// kernel transaction; push and pop may coincide, flush empties it in one cycle.
module ap_ctrl_ts_fifo
  import ap_ctrl_driver_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == LAST) ? '0 : wptr + AW'(1);
      if (do_pop)  rptr <= (rptr == LAST) ? '0 : rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only occupancy tracking does.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= din;
  end

endmodule

// File: rtl/ap_ctrl_driver.sv
// Initiator for the ap_ctrl_chain handshake: issues a programmed number of
// kernel starts with bounded overlap, throttles ap_continue and times each run.
module ap_ctrl_driver
  import ap_ctrl_driver_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int MAX_OUT = 4,
  parameter int DLY_W   = 8
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             cmd_start,
  input  logic [CNT_W-1:0] cmd_num_txn,
  input  logic             cmd_abort,
  input  logic [DLY_W-1:0] cfg_cont_delay,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] txn_issued,
  output logic [CNT_W-1:0] txn_done,
  output logic             lat_valid,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] max_latency,
  output logic             proto_err
);

  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  state_t           state;
  state_t           state_nxt;
  logic             start_nxt;
  logic [CNT_W-1:0] ts;
  logic [CNT_W-1:0] num;
  logic [DLY_W-1:0] dly;
  logic [DLY_W-1:0] hc;
  logic [CNT_W-1:0] issued_nxt;
  logic [CNT_W-1:0] done_nxt;
  logic [CNT_W-1:0] out_nxt;
  logic [CNT_W-1:0] head;
  logic [CNT_W-1:0] lat_now;
  logic             start_acc;
  logic             done_hs;
  logic             done_acc;
  logic             spurious;
  logic             launch;
  logic             fifo_full;
  logic             fifo_empty;

  assign start_acc  = ap_start && ap_ready;
  assign done_hs    = ap_done && ap_continue;
  // A completion only counts when a started transaction is waiting for it.
  assign done_acc   = done_hs && (state != IDLE) && !fifo_empty;
  assign spurious   = done_hs && !done_acc;
  assign launch     = (state == IDLE) && cmd_start && !cmd_abort;
  assign issued_nxt = txn_issued + CNT_W'(start_acc);
  assign done_nxt   = txn_done + CNT_W'(done_acc);
  assign out_nxt    = issued_nxt - done_nxt;
  assign lat_now    = ts - head;

  ap_ctrl_ts_fifo #(
    .W     (CNT_W),
    .DEPTH (MAX_OUT)
  ) u_ts_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (start_acc && (!fifo_full || done_acc)),
    .pop   (done_acc),
    .flush (cmd_abort || launch),
    .din   (ts),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= IDLE;
      ap_start <= 1'b0;
    end else begin
      state    <= state_nxt;
      ap_start <= start_nxt;
    end
  end

  // ap_start is computed from post-handshake counts so it drops the cycle
  // after the window fills and never falls while a start is still pending.
  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    if (cmd_abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_start) begin
            state_nxt = (cmd_num_txn != '0) ? ISSUE : FIN;
            start_nxt = (cmd_num_txn != '0);
          end
        end
        ISSUE: begin
          if (issued_nxt == num) state_nxt = DRAIN;
          else                   start_nxt = (out_nxt < MAX_OUT_C);
        end
        DRAIN: begin
          if (txn_done == num) state_nxt = FIN;
        end
        FIN:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state != IDLE);
    finish      = (state == FIN);
    ap_continue = (hc == '0);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ts           <= '0;
      num          <= '0;
      dly          <= '0;
      txn_issued   <= '0;
      txn_done     <= '0;
      hc           <= '0;
      proto_err    <= 1'b0;
      lat_valid    <= 1'b0;
      last_latency <= '0;
      max_latency  <= '0;
    end else begin
      ts        <= ts + CNT_W'(1);
      lat_valid <= done_acc;
      if (launch) begin
        num         <= cmd_num_txn;
        dly         <= cfg_cont_delay;
        txn_issued  <= '0;
        txn_done    <= '0;
        max_latency <= '0;
        proto_err   <= 1'b0;
      end else begin
        txn_issued <= issued_nxt;
        txn_done   <= done_nxt;
        if (spurious) proto_err <= 1'b1;
        if (done_acc) begin
          last_latency <= lat_now;
          if (lat_now > max_latency) max_latency <= lat_now;
        end
      end
      if (cmd_abort)      hc <= '0;
      else if (done_acc)  hc <= dly;
      else if (hc != '0)  hc <= hc - DLY_W'(1);
    end
  end

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Directed bench for ap_ctrl_driver: a behavioural kernel answers the handshake,
// expected latencies/finish results are queued and checked by a monitor.
module tb_ap_ctrl_driver;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic [31:0] cmd_num_txn = '0;
  logic        cmd_abort = 1'b0;
  logic [7:0]  cfg_cont_delay = '0;
  logic        ap_start;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        ap_continue;
  logic        busy;
  logic        finish;
  logic [31:0] txn_issued;
  logic [31:0] txn_done;
  logic        lat_valid;
  logic [31:0] last_latency;
  logic [31:0] max_latency;
  logic        proto_err;

  ap_ctrl_driver #(.CNT_W(32), .MAX_OUT(4), .DLY_W(8)) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .cmd_start      (cmd_start),
    .cmd_num_txn    (cmd_num_txn),
    .cmd_abort      (cmd_abort),
    .cfg_cont_delay (cfg_cont_delay),
    .ap_start       (ap_start),
    .ap_ready       (ap_ready),
    .ap_done        (ap_done),
    .ap_continue    (ap_continue),
    .busy           (busy),
    .finish         (finish),
    .txn_issued     (txn_issued),
    .txn_done       (txn_done),
    .lat_valid      (lat_valid),
    .last_latency   (last_latency),
    .max_latency    (max_latency),
    .proto_err      (proto_err)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int done;
    int maxl;
  } fin_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_lat[$];
  fin_t exp_fin[$];

  // Kernel configuration, written only by the stimulus thread.
  int k_lat = 1;
  int k_ilim = 0;
  int k_dlim = 0;
  int k_gen = 0;
  logic k_force = 1'b0;

  // Kernel state, owned by the kernel process.
  int kcyc = 0;
  int k_acc = 0;
  int k_dn = 0;
  int k_seen_gen = 0;
  int dueq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Kernel: answers at the falling edge so the next rising edge sees stable inputs.
  always @(negedge ap_clk) begin
    kcyc++;
    if (k_gen != k_seen_gen) begin
      k_seen_gen = k_gen;
      dueq.delete();
      k_acc = 0;
      k_dn = 0;
    end
    ap_ready = (k_acc < k_ilim);
    ap_done  = k_force || ((dueq.size() > 0) && (k_dn < k_dlim) && (kcyc >= dueq[0]));
    if (ap_start && ap_ready) begin
      dueq.push_back(kcyc + k_lat);
      k_acc++;
    end
    if (ap_done && ap_continue && (dueq.size() > 0)) begin
      void'(dueq.pop_front());
      k_dn++;
    end
  end

  // Monitor: scoreboards every latency report and every finish pulse.
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (lat_valid) begin
        if (exp_lat.size() == 0) check("lat_valid with nothing expected", {31'b0, lat_valid}, 32'd0);
        else                     check("last_latency", last_latency, exp_lat.pop_front());
      end
      if (finish) begin
        if (exp_fin.size() == 0) begin
          check("finish with no run expected", {31'b0, finish}, 32'd0);
        end else begin
          fin_t f;
          f = exp_fin.pop_front();
          check("finish txn_done", txn_done, f.done);
          check("finish max_latency", max_latency, f.maxl);
        end
      end
    end
  end

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      0:       return txn_issued;
      1:       return txn_done;
      default: return {31'b0, busy};
    endcase
  endfunction

  // Waits at falling edges until the selected signal equals n; a timeout shows as a failed check.
  task automatic wait_for(input string name, input int sel, input int n, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge ap_clk);
      k++;
    end while ((probe(sel) != n) && (k < budget));
    check(name, probe(sel), n);
  endtask

  task automatic kreset(input int lat, input int ilim, input int dlim);
    k_lat  = lat;
    k_ilim = ilim;
    k_dlim = dlim;
    k_gen++;
  endtask

  task automatic launch(input int num, input int dly);
    @(posedge ap_clk); #1;
    cmd_num_txn    = num;
    cfg_cont_delay = dly[7:0];
    cmd_start      = 1'b1;
    @(posedge ap_clk); #1;
    cmd_start      = 1'b0;
  endtask

  task automatic settle();
    wait_for("return to idle", 2, 0, 80);
    repeat (6) @(negedge ap_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got t=%0t, expected < 100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    fin_t f;
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("reset ap_start", {31'b0, ap_start}, 0);
    check("reset ap_continue", {31'b0, ap_continue}, 1);
    check("reset busy", {31'b0, busy}, 0);
    check("reset proto_err", {31'b0, proto_err}, 0);
    check("reset txn_issued", txn_issued, 0);
    check("reset max_latency", max_latency, 0);

    // Zero-length run: one FIN cycle, no starts.
    f.done = 0; f.maxl = 0; exp_fin.push_back(f);
    kreset(1, 100, 100);
    launch(0, 0);
    @(negedge ap_clk);
    check("zero run busy", {31'b0, busy}, 1);
    check("zero run finish", {31'b0, finish}, 1);
    check("zero run ap_start", {31'b0, ap_start}, 0);
    @(negedge ap_clk);
    check("zero run busy after", {31'b0, busy}, 0);
    check("zero run ap_start after", {31'b0, ap_start}, 0);
    settle();

    // Three back-to-back transactions, 5-cycle kernel.
    repeat (3) exp_lat.push_back(5);
    f.done = 3; f.maxl = 5; exp_fin.push_back(f);
    kreset(5, 100, 100);
    launch(3, 0);
    settle();
    check("run3 txn_issued", txn_issued, 3);
    check("run3 txn_done", txn_done, 3);

    // Outstanding window: 8 transactions, kernel takes 10 cycles.
    repeat (8) exp_lat.push_back(10);
    f.done = 8; f.maxl = 10; exp_fin.push_back(f);
    kreset(10, 100, 100);
    launch(8, 0);
    wait_for("window fill", 0, 4, 20);
    check("window full ap_start", {31'b0, ap_start}, 0);
    repeat (3) begin
      @(negedge ap_clk);
      check("window held ap_start", {31'b0, ap_start}, 0);
    end
    wait_for("first completion", 1, 1, 20);
    check("window reopen ap_start", {31'b0, ap_start}, 1);
    check("window reopen txn_issued", txn_issued, 4);
    settle();
    check("run8 txn_issued", txn_issued, 8);

    // ap_continue hold-off of 3 cycles.
    exp_lat.push_back(2);
    exp_lat.push_back(5);
    f.done = 2; f.maxl = 5; exp_fin.push_back(f);
    kreset(2, 100, 100);
    launch(2, 3);
    wait_for("holdoff first done", 1, 1, 20);
    check("holdoff cycle1 ap_continue", {31'b0, ap_continue}, 0);
    @(negedge ap_clk);
    check("holdoff cycle2 ap_continue", {31'b0, ap_continue}, 0);
    @(negedge ap_clk);
    check("holdoff cycle3 ap_continue", {31'b0, ap_continue}, 0);
    @(negedge ap_clk);
    check("holdoff release ap_continue", {31'b0, ap_continue}, 1);
    check("holdoff release txn_done", txn_done, 1);
    @(negedge ap_clk);
    check("holdoff second accept txn_done", txn_done, 2);
    settle();

    // Abort with two outstanding after five starts.
    repeat (3) exp_lat.push_back(2);
    kreset(2, 5, 3);
    launch(8, 0);
    wait_for("abort setup issued", 0, 5, 30);
    check("abort setup done", txn_done, 3);
    @(posedge ap_clk); #1;
    cmd_abort = 1'b1;
    @(posedge ap_clk); #1;
    cmd_abort = 1'b0;
    @(negedge ap_clk);
    check("abort busy", {31'b0, busy}, 0);
    check("abort ap_start", {31'b0, ap_start}, 0);
    check("abort txn_issued held", txn_issued, 5);
    check("abort txn_done held", txn_done, 3);
    check("abort ap_continue", {31'b0, ap_continue}, 1);
    repeat (4) @(negedge ap_clk);
    exp_lat.push_back(4);
    exp_lat.push_back(4);
    f.done = 2; f.maxl = 4; exp_fin.push_back(f);
    kreset(4, 100, 100);
    launch(2, 0);
    settle();
    check("post-abort txn_done", txn_done, 2);
    check("post-abort proto_err", {31'b0, proto_err}, 0);

    // Spurious completion while idle.
    @(posedge ap_clk); #1;
    k_force = 1'b1;
    @(posedge ap_clk); #1;
    k_force = 1'b0;
    @(negedge ap_clk);
    check("spurious proto_err", {31'b0, proto_err}, 1);
    check("spurious txn_done", txn_done, 2);
    check("spurious txn_issued", txn_issued, 2);
    repeat (3) @(negedge ap_clk);
    check("sticky proto_err", {31'b0, proto_err}, 1);
    exp_lat.push_back(3);
    f.done = 1; f.maxl = 3; exp_fin.push_back(f);
    kreset(3, 100, 100);
    launch(1, 0);
    @(negedge ap_clk);
    check("proto_err cleared by start", {31'b0, proto_err}, 0);
    settle();

    // Asynchronous reset while a start is pending.
    kreset(3, 0, 0);
    launch(8, 0);
    @(negedge ap_clk);
    check("pre-reset ap_start", {31'b0, ap_start}, 1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("async reset ap_start", {31'b0, ap_start}, 0);
    check("async reset busy", {31'b0, busy}, 0);
    check("async reset txn_issued", txn_issued, 0);
    @(posedge ap_clk); #2;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("after reset ap_start", {31'b0, ap_start}, 0);
    check("after reset ap_continue", {31'b0, ap_continue}, 1);

    check("pending latency expectations", exp_lat.size(), 0);
    check("pending finish expectations", exp_fin.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
